// File: rtl/patch_dispatcher_if.sv
// Bus bundle between the patch dispatcher, its upstream descriptor source and the reducer bank.
// slave is the dispatcher's view; master is the upstream/reducer side.
interface patch_dispatcher_if #(
    parameter int unsigned N_REDUCER  = 4,
    parameter int unsigned N_PATCH    = 16,
    parameter int unsigned PATCH_SIZE = 6,
    parameter int unsigned N_COL_SIZE = 11,
    parameter int unsigned N_ROW_SIZE = 11,
    parameter int unsigned FP_SIZE    = 32
);
    localparam int unsigned PN = $clog2(N_PATCH);
    localparam int unsigned RN = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1;

    logic                          desc_valid;
    logic                          desc_ack;
    logic [PN-1:0]                 desc_patch_num;
    logic [N_ROW_SIZE-1:0]         desc_row;
    logic [N_COL_SIZE-1:0]         desc_col;
    logic [FP_SIZE-1:0]            desc_sum;
    logic [PATCH_SIZE*FP_SIZE-1:0] desc_weights;

    logic [N_REDUCER-1:0]          red_available;
    logic [N_REDUCER-1:0]          red_done;
    logic [N_REDUCER*FP_SIZE-1:0]  red_sum;
    logic [N_REDUCER*PN-1:0]       red_patch_num;
    logic [N_REDUCER-1:0]          red_init;

    logic [PN-1:0]                 conf_patch_num;
    logic [N_ROW_SIZE-1:0]         conf_row;
    logic [N_COL_SIZE-1:0]         conf_col;
    logic [FP_SIZE-1:0]            conf_sum;
    logic [PATCH_SIZE*FP_SIZE-1:0] conf_weights;

    logic                          res_valid;
    logic                          res_ready;
    logic [PN-1:0]                 res_patch_num;
    logic [FP_SIZE-1:0]            res_sum;
    logic [RN-1:0]                 res_reducer;
    logic                          idle;

    modport slave (
        input  desc_valid, desc_patch_num, desc_row, desc_col, desc_sum, desc_weights,
        input  red_available, red_done, red_sum, red_patch_num, res_ready,
        output desc_ack, red_init, conf_patch_num, conf_row, conf_col, conf_sum, conf_weights,
        output res_valid, res_patch_num, res_sum, res_reducer, idle
    );

    modport master (
        output desc_valid, desc_patch_num, desc_row, desc_col, desc_sum, desc_weights,
        output red_available, red_done, red_sum, red_patch_num, res_ready,
        input  desc_ack, red_init, conf_patch_num, conf_row, conf_col, conf_sum, conf_weights,
        input  res_valid, res_patch_num, res_sum, res_reducer, idle
    );
endinterface

// File: rtl/patch_dispatcher.sv
// Dispatches patch descriptors to free reducers via a one-hot init pulse and collects their
// results into a round-robin valid/ready output.
module patch_dispatcher #(
    parameter int unsigned N_REDUCER  = 4,
    parameter int unsigned N_PATCH    = 16,
    parameter int unsigned PATCH_SIZE = 6,
    parameter int unsigned N_COL_SIZE = 11,
    parameter int unsigned N_ROW_SIZE = 11,
    parameter int unsigned FP_SIZE    = 32
) (
    input logic              CLK,
    input logic              RESET_N,
    patch_dispatcher_if.slave bus
);
    localparam int unsigned PN = $clog2(N_PATCH);
    localparam int unsigned RN = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1;

    logic [N_REDUCER-1:0]          eligible, init_d, red_init_q;
    logic [N_REDUCER-1:0]          pending_q, pending_d, pend_clr;
    logic                          desc_ack, pick_found;
    logic [PN-1:0]                 conf_pn_q;
    logic [N_ROW_SIZE-1:0]         conf_row_q;
    logic [N_COL_SIZE-1:0]         conf_col_q;
    logic [FP_SIZE-1:0]            conf_sum_q;
    logic [PATCH_SIZE*FP_SIZE-1:0] conf_w_q;
    logic [FP_SIZE-1:0]            hold_sum_q [N_REDUCER];
    logic [PN-1:0]                 hold_pn_q  [N_REDUCER];
    logic                          res_valid_q, res_valid_d, load_en, sel_found;
    logic [FP_SIZE-1:0]            res_sum_q, res_sum_d;
    logic [PN-1:0]                 res_pn_q, res_pn_d;
    logic [RN-1:0]                 res_red_q, res_red_d, rr_ptr_q, rr_ptr_d, sel_idx, cand;

    // A reducer still looks available in its init cycle, and a held result must not be clobbered.
    always_comb begin
        eligible   = bus.red_available & ~pending_q & ~red_init_q;
        desc_ack   = RESET_N & bus.desc_valid & (|eligible);
        init_d     = '0;
        pick_found = 1'b0;
        for (int unsigned k = 0; k < N_REDUCER; k++) begin
            if (eligible[k] && !pick_found) begin
                init_d[k]  = 1'b1;
                pick_found = 1'b1;
            end
        end
        if (!desc_ack) init_d = '0;
    end

    // Circular search for the next pending result, starting just after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REDUCER; i++) begin
            cand = RN'((32'(rr_ptr_q) + i) % N_REDUCER);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        load_en     = ~res_valid_q | bus.res_ready;
        pend_clr    = '0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_pn_d    = res_pn_q;
        res_red_d   = res_red_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            res_valid_d = sel_found;
            if (sel_found) begin
                pend_clr[sel_idx] = 1'b1;
                res_sum_d         = hold_sum_q[sel_idx];
                res_pn_d          = hold_pn_q[sel_idx];
                res_red_d         = sel_idx;
                rr_ptr_d          = sel_idx;
            end
        end
        pending_d = (pending_q & ~pend_clr) | bus.red_done;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            red_init_q  <= '0;
            conf_pn_q   <= '0;
            conf_row_q  <= '0;
            conf_col_q  <= '0;
            conf_sum_q  <= '0;
            conf_w_q    <= '0;
            pending_q   <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_pn_q    <= '0;
            res_red_q   <= '0;
            rr_ptr_q    <= RN'(N_REDUCER - 1);
            for (int unsigned k = 0; k < N_REDUCER; k++) begin
                hold_sum_q[k] <= '0;
                hold_pn_q[k]  <= '0;
            end
        end else begin
            red_init_q <= init_d;
            if (desc_ack) begin
                conf_pn_q  <= bus.desc_patch_num;
                conf_row_q <= bus.desc_row;
                conf_col_q <= bus.desc_col;
                conf_sum_q <= bus.desc_sum;
                conf_w_q   <= bus.desc_weights;
            end
            for (int unsigned k = 0; k < N_REDUCER; k++) begin
                if (bus.red_done[k]) begin
                    hold_sum_q[k] <= bus.red_sum[k*FP_SIZE +: FP_SIZE];
                    hold_pn_q[k]  <= bus.red_patch_num[k*PN +: PN];
                end
            end
            pending_q   <= pending_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_pn_q    <= res_pn_d;
            res_red_q   <= res_red_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.desc_ack       = desc_ack;
    assign bus.red_init       = red_init_q;
    assign bus.conf_patch_num = conf_pn_q;
    assign bus.conf_row       = conf_row_q;
    assign bus.conf_col       = conf_col_q;
    assign bus.conf_sum       = conf_sum_q;
    assign bus.conf_weights   = conf_w_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_sum        = res_sum_q;
    assign bus.res_patch_num  = res_pn_q;
    assign bus.res_reducer    = res_red_q;
    assign bus.idle           = (&bus.red_available) & ~(|pending_q) & ~res_valid_q;
endmodule

// File: tb/tb_patch_dispatcher.sv
// Directed bench for patch_dispatcher: dispatch ordering, eligibility masking, result
// collection order and asynchronous reset.
module tb_patch_dispatcher;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    patch_dispatcher_if bus ();

    patch_dispatcher dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input int row, input int col, input int pn);
        bus.desc_row       = 11'(row);
        bus.desc_col       = 11'(col);
        bus.desc_patch_num = 4'(pn);
        bus.desc_sum       = 32'h0;
        bus.desc_weights   = {6{32'h3F800000}};
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.desc_valid    = 1'b1;
        set_desc(0, 0, 0);
        bus.red_available = 4'b1111;
        bus.red_done      = 4'b0000;
        bus.red_sum       = '0;
        bus.red_patch_num = '0;
        bus.res_ready     = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_red_init", bus.red_init, 4'b0000);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_desc_ack", bus.desc_ack, 1'b0);
        check("rst_idle", bus.idle, 1'b1);
        check("rst_conf_row", bus.conf_row, 11'd0);
        bus.desc_valid = 1'b0;
        rst_n          = 1'b1;
        tick();
        check("post_rst_idle", bus.idle, 1'b1);
        check("post_rst_init", bus.red_init, 4'b0000);

        // Lowest-index dispatch, back-to-back
        set_desc(5, 10, 3);
        bus.desc_valid = 1'b1;
        #1;
        check("d1_ack", bus.desc_ack, 1'b1);
        tick();
        set_desc(6, 12, 4);
        #1;
        check("d1_init", bus.red_init, 4'b0001);
        check("d1_row", bus.conf_row, 11'd5);
        check("d1_col", bus.conf_col, 11'd10);
        check("d1_pn", bus.conf_patch_num, 4'd3);
        check("d2_ack", bus.desc_ack, 1'b1);
        tick();
        bus.desc_valid = 1'b0;
        check("d2_init", bus.red_init, 4'b0010);
        check("d2_row", bus.conf_row, 11'd6);
        check("d2_col", bus.conf_col, 11'd12);
        check("d2_pn", bus.conf_patch_num, 4'd4);
        tick();
        check("d2_init_drop", bus.red_init, 4'b0000);
        check("d2_conf_hold", bus.conf_row, 11'd6);

        // No eligible reducer
        bus.red_available = 4'b0000;
        set_desc(7, 20, 6);
        bus.desc_valid = 1'b1;
        #1;
        check("ne_ack0", bus.desc_ack, 1'b0);
        tick();
        check("ne_init0", bus.red_init, 4'b0000);
        check("ne_ack1", bus.desc_ack, 1'b0);
        tick();
        check("ne_init1", bus.red_init, 4'b0000);
        bus.red_available = 4'b0100;
        #1;
        check("ne_ack_free", bus.desc_ack, 1'b1);
        tick();
        check("ne_init_free", bus.red_init, 4'b0100);
        check("ne_row", bus.conf_row, 11'd7);
        bus.desc_valid    = 1'b0;
        bus.red_available = 4'b0000;
        tick();
        check("ne_init_drop", bus.red_init, 4'b0000);

        // Simultaneous results from reducers 0 and 2
        bus.red_done      = 4'b0101;
        bus.red_sum       = {32'h0, 32'h40400000, 32'h0, 32'h3F800000};
        bus.red_patch_num = {4'd0, 4'd5, 4'd0, 4'd3};
        tick();
        bus.red_done      = 4'b0000;
        bus.red_sum       = {4{32'hDEADBEEF}};
        bus.red_patch_num = 16'hFFFF;
        check("sim_t1_valid", bus.res_valid, 1'b0);
        tick();
        check("sim_t2_valid", bus.res_valid, 1'b1);
        check("sim_t2_red", bus.res_reducer, 2'd0);
        check("sim_t2_sum", bus.res_sum, 32'h3F800000);
        check("sim_t2_pn", bus.res_patch_num, 4'd3);
        check("sim_t2_idle", bus.idle, 1'b0);
        tick();
        check("sim_hold_valid", bus.res_valid, 1'b1);
        check("sim_hold_red", bus.res_reducer, 2'd0);
        check("sim_hold_sum", bus.res_sum, 32'h3F800000);
        bus.res_ready = 1'b1;
        tick();
        check("sim_2_valid", bus.res_valid, 1'b1);
        check("sim_2_red", bus.res_reducer, 2'd2);
        check("sim_2_sum", bus.res_sum, 32'h40400000);
        check("sim_2_pn", bus.res_patch_num, 4'd5);
        tick();
        check("sim_drained", bus.res_valid, 1'b0);
        bus.res_ready = 1'b0;

        // Pending result blocks dispatch to its reducer until it reaches the output register
        bus.red_done      = 4'b1001;
        bus.red_sum       = {32'h40A00000, 32'h0, 32'h0, 32'h40C00000};
        bus.red_patch_num = {4'd9, 4'd0, 4'd0, 4'd7};
        tick();
        bus.red_done      = 4'b0000;
        bus.red_available = 4'b0001;
        set_desc(9, 1, 2);
        bus.desc_valid = 1'b1;
        #1;
        check("pb_ack_pend", bus.desc_ack, 1'b0);
        tick();
        check("pb_red3", bus.res_reducer, 2'd3);
        check("pb_sum3", bus.res_sum, 32'h40A00000);
        check("pb_ack_held", bus.desc_ack, 1'b0);
        tick();
        check("pb_ack_held2", bus.desc_ack, 1'b0);
        check("pb_init_none", bus.red_init, 4'b0000);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("pb_red0", bus.res_reducer, 2'd0);
        check("pb_sum0", bus.res_sum, 32'h40C00000);
        check("pb_pn0", bus.res_patch_num, 4'd7);
        check("pb_ack_free", bus.desc_ack, 1'b1);
        tick();
        check("pb_init", bus.red_init, 4'b0001);
        check("pb_row", bus.conf_row, 11'd9);
        check("pb_ack_mask", bus.desc_ack, 1'b0);

        // Asynchronous reset while init pulse and result are both live
        bus.red_available = 4'b0010;
        set_desc(11, 2, 1);
        tick();
        bus.desc_valid    = 1'b0;
        bus.red_available = 4'b0000;
        check("ar_init_live", bus.red_init, 4'b0010);
        check("ar_valid_live", bus.res_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_init_cleared", bus.red_init, 4'b0000);
        check("ar_valid_cleared", bus.res_valid, 1'b0);
        tick();
        bus.red_available = 4'b1111;
        rst_n             = 1'b1;
        tick();
        tick();
        check("ar_no_stale", bus.res_valid, 1'b0);
        check("ar_idle", bus.idle, 1'b1);
        check("ar_init_quiet", bus.red_init, 4'b0000);
        check("ar_conf_cleared", bus.conf_row, 11'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
